video_timing_rx: RTL and testbench

Receive-side video timing recovery for the DVI/VGA pixel path. It takes a registered hsync/vsync/de stream in the pixel clock domain and recovers active-area pixel coordinates (sx, sy). It measures active line width and frame height, and asserts `locked` once the timing has been stable for a set number of frames. It sits behind a capture front end, or in loopback behind `simple_480p`, and feeds downstream pixel consumers and self-checking logic.

---
 rtl/video_timing_rx.sv | 121 ++++++++++++
 tb/tb_video_timing_rx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/video_timing_rx.sv
// video_timing_rx: recover active-area coordinates, measure line/frame geometry and lock onto incoming video timing
module video_timing_rx #(
  parameter int CORDW       = 10,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             de_out,
  output logic             line_start,
  output logic             frame_start,
  output logic [CORDW-1:0] h_active,
  output logic [CORDW-1:0] v_active,
  output logic             locked,
  output logic             err
);
  typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} state_t;
  localparam logic [CORDW-1:0] MAX = '1;
  state_t state, state_n;
  logic hs1, vs1, de1, vs2, de2, unused_hs;
  logic vs_edge, de_fall, de_rise, sat, h_bad, mis_all, fs_pend;
  logic hv, mis, hv_n, mis_n, err_n;
  logic [CORDW-1:0] run, lines, run_n, lines_n, height, h_n, v_n;
  logic [3:0] fcnt, fcnt_n;
  assign unused_hs = hs1;
  assign vs_edge = vs1 & ~vs2;
  assign de_fall = de2 & ~de1;
  assign de_rise = de1 & ~de2;
  assign run_n   = de_rise ? CORDW'(1) : (de1 && run != MAX) ? run + 1'b1 : run;
  assign height  = (de_fall && lines != MAX) ? lines + 1'b1 : lines;
  assign lines_n = vs_edge ? '0 : height;
  // the run saturates on the pixel whose column first reads MAX; the line counter when it first reaches MAX
  assign sat     = (de1 & ~de_rise & (run == MAX) & (sx != MAX)) | (de_fall & (lines == MAX - 1'b1));
  assign h_bad   = de_fall & (run != h_active);
  assign mis_all = mis | sat | (hv & h_bad);
  // lock state machine: next state, measurement writes and error pulse
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    h_n     = h_active;
    v_n     = v_active;
    hv_n    = hv;
    mis_n   = mis;
    err_n   = sat;
    case (state)
      SEARCH: begin
        if (vs_edge) begin
          state_n = MEASURE;
          hv_n    = 1'b0;
          mis_n   = 1'b0;
        end
      end
      MEASURE: begin
        mis_n = mis_all;
        if (de_fall && !hv) begin
          h_n  = run;
          hv_n = 1'b1;
        end
        if (vs_edge) begin
          hv_n  = 1'b0;
          mis_n = 1'b0;
          if (!mis_all && height != '0) begin
            v_n     = height;
            fcnt_n  = '0;
            state_n = CHECK;
          end else err_n = 1'b1;
        end
      end
      default: begin
        if (sat || h_bad || (vs_edge && height != v_active)) begin
          err_n   = 1'b1;
          state_n = MEASURE;
          fcnt_n  = '0;
          hv_n    = 1'b0;
          mis_n   = sat & ~vs_edge;
        end else if (vs_edge && state == CHECK) begin
          fcnt_n  = fcnt + 4'd1;
          state_n = (fcnt_n == 4'(LOCK_FRAMES)) ? LOCKED : CHECK;
        end
      end
    endcase
  end
  // input stage, counters, aligned pixel outputs and lock state registers
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      {hs1, vs1, de1, vs2, de2, fs_pend} <= '0;
      {run, lines, sx, sy, h_active, v_active} <= '0;
      {de_out, line_start, frame_start, locked, err, hv, mis} <= '0;
      fcnt  <= '0;
      state <= SEARCH;
    end else begin
      hs1         <= HS_POL ? hsync : ~hsync;
      vs1         <= VS_POL ? vsync : ~vsync;
      de1         <= de;
      vs2         <= vs1;
      de2         <= de1;
      run         <= run_n;
      lines       <= lines_n;
      fs_pend     <= ~de_rise & (vs_edge | fs_pend);
      de_out      <= de1;
      sx          <= de_rise ? '0 : run;
      sy          <= vs_edge ? '0 : lines;
      line_start  <= de_rise;
      frame_start <= de_rise & (vs_edge | fs_pend);
      state       <= state_n;
      fcnt        <= fcnt_n;
      h_active    <= h_n;
      v_active    <= v_n;
      hv          <= hv_n;
      mis         <= mis_n;
      err         <= err_n;
      locked      <= state_n == LOCKED;
    end
  end
endmodule

// File: tb/tb_video_timing_rx.sv
// tb_video_timing_rx: directed frames on a small raster against both sync polarities
module tb_video_timing_rx;
  localparam int HA = 16, HT = 24, VA = 6, VT = 10;
  typedef struct packed {logic v, de, ls, fs; logic [9:0] sx, sy;} exp_t;
  logic clk = 1'b0, rst;
  logic hs_n, vs_n, hs_p, vs_p, de_in;
  logic [9:0] sx0, sy0, ha0, va0, sx1, sy1, ha1, va1;
  logic deo0, ls0, fs0, lk0, er0, deo1, ls1, fs1, lk1, er1;
  logic [44:0] out0, out1;
  exp_t cur, e1, e2;
  logic sb_en, pend, prev_d, prev_v, ls, prev_lk, err_lk, err_prev;
  int checks = 0, errors = 0, cyc = 0, errs0 = 0, errs1 = 0;
  int vs_cyc = 0, lock_cyc = 0, err_cyc = 0, short_fall = 0;
  logic [9:0] err_sx;
  always #5 clk = ~clk;
  video_timing_rx dut0 (
    .clk_pix(clk), .rst_pix(rst), .hsync(hs_n), .vsync(vs_n), .de(de_in),
    .sx(sx0), .sy(sy0), .de_out(deo0), .line_start(ls0), .frame_start(fs0),
    .h_active(ha0), .v_active(va0), .locked(lk0), .err(er0)
  );
  video_timing_rx #(.HS_POL(1'b1), .VS_POL(1'b1)) dut1 (
    .clk_pix(clk), .rst_pix(rst), .hsync(hs_p), .vsync(vs_p), .de(de_in),
    .sx(sx1), .sy(sy1), .de_out(deo1), .line_start(ls1), .frame_start(fs1),
    .h_active(ha1), .v_active(va1), .locked(lk1), .err(er1)
  );
  assign out0 = {sx0, sy0, deo0, ls0, fs0, ha0, va0, lk0, er0};
  assign out1 = {sx1, sy1, deo1, ls1, fs1, ha1, va1, lk1, er1};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic h, input logic v, input logic d, input int ex, input int ey, input logic r);
    @(posedge clk);
    #1;
    if (rst) begin
      chk("rst_outputs", out0, '0);
      chk("rst_outputs_pol", out1, '0);
    end
    rst = r;
    hs_n = ~h; vs_n = ~v; hs_p = h; vs_p = v; de_in = d;
    if (v && !prev_v) begin
      pend = 1'b1;
      vs_cyc = cyc;
    end
    ls = d && !prev_d;
    cur = '{sb_en, d, ls, ls && pend, 10'(ex), 10'(ey)};
    if (ls) pend = 1'b0;
    if (r) begin
      pend = 1'b0; prev_v = 1'b0; prev_d = 1'b0;
    end else begin
      prev_d = d; prev_v = v;
    end
  endtask
  task automatic frame(input int nl, input int short_y, input bit do_rst);
    sb_en = 1'b1;
    for (int y = 0; y < VT; y++)
      for (int x = 0; x < HT; x++) begin
        int w;
        logic d, r;
        w = (y == short_y) ? HA - 1 : HA;
        d = (y < nl) && (x < w);
        r = do_rst && y == 2 && x == 5;
        if (r) sb_en = 1'b0;
        drive(x >= HA + 2 && x < HA + 5, y == VA + 1 || y == VA + 2, d, x, y, r);
        if (y == short_y && x == w) short_fall = cyc;
      end
  endtask
  task automatic lock_is(input string tag, input logic exp);
    chk(tag, lk0, exp);
    chk({tag, "_pol"}, lk1, exp);
  endtask
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      e1 <= '0; e2 <= '0;
    end else begin
      e1 <= cur; e2 <= e1;
    end
  end
  always @(negedge clk) begin
    if (e2.v) begin
      chk("de_out", deo0, e2.de); chk("de_out_pol", deo1, e2.de);
      chk("line_start", ls0, e2.ls); chk("line_start_pol", ls1, e2.ls);
      chk("frame_start", fs0, e2.fs); chk("frame_start_pol", fs1, e2.fs);
      if (e2.de) begin
        chk("sx", sx0, e2.sx); chk("sx_pol", sx1, e2.sx);
        chk("sy", sy0, e2.sy); chk("sy_pol", sy1, e2.sy);
      end
    end
    if (er0) begin
      errs0++; err_cyc = cyc; err_sx = sx0; err_lk = lk0; err_prev = prev_lk;
    end
    if (er1) errs1++;
    if (lk0 && !prev_lk) lock_cyc = cyc;
    prev_lk = lk0;
  end
  initial begin
    rst = 1'b1; hs_n = 1'b1; vs_n = 1'b1; hs_p = 1'b0; vs_p = 1'b0; de_in = 1'b0;
    sb_en = 1'b0; pend = 1'b0; prev_d = 1'b0; prev_v = 1'b0; prev_lk = 1'b0; cur = '0;
    repeat (3) drive(0, 0, 0, 0, 0, 1);
    frame(VA, -1, 0);
    frame(VA, -1, 0);
    chk("h_active", ha0, HA); chk("h_active_pol", ha1, HA);
    chk("v_active", va0, VA); chk("v_active_pol", va1, VA);
    lock_is("locked_f2", 0);
    frame(VA, -1, 0);
    lock_is("locked_f3", 0);
    frame(VA, -1, 0);
    lock_is("locked_f4", 1);
    chk("lock_latency", lock_cyc - vs_cyc, 2);
    chk("errs_clean", errs0, 0);
    frame(VA, 3, 0);
    chk("errs_short_line", errs0, 1);
    chk("short_err_latency", err_cyc - short_fall, 2);
    chk("locked_before_err", err_prev, 1);
    chk("locked_at_err", err_lk, 0);
    lock_is("locked_f5", 0);
    frame(VA, -1, 0);
    lock_is("locked_f6", 0);
    frame(VA, -1, 0);
    lock_is("relock_f7", 1);
    frame(VA - 1, -1, 0);
    chk("errs_short_frame", errs0, 2);
    chk("locked_before_vs_err", err_prev, 1);
    chk("locked_at_vs_err", err_lk, 0);
    chk("v_active_held", va0, VA);
    lock_is("locked_f8", 0);
    frame(VA, -1, 0);
    chk("v_active_clean", va0, VA); chk("v_active_clean_pol", va1, VA);
    frame(VA, -1, 0);
    frame(VA, -1, 0);
    lock_is("relock_f11", 1);
    frame(VA, -1, 1);
    lock_is("locked_after_rst", 0);
    chk("h_active_after_rst", ha0, 0);
    chk("errs_rst", errs0, 2);
    frame(VA, -1, 0);
    frame(VA, -1, 0);
    lock_is("locked_f14", 0);
    frame(VA, -1, 0);
    lock_is("relock_f15", 1);
    for (int k = 0; k < 1100; k++) drive(0, 0, 1, k > 1023 ? 1023 : k, 0, 0);
    repeat (20) drive(0, 0, 0, 0, 0, 0);
    chk("errs_sat", errs0, 3);
    chk("errs_pol", errs1, 3);
    chk("sat_sx_at_err", err_sx, 1023);
    chk("locked_before_sat", err_prev, 1);
    lock_is("locked_sat", 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
